// File: rtl/vectored_timer_responder_if.sv
// 68000-side bus signals of the vectored timer responder, grouped for port use.
interface vectored_timer_responder_if;
    logic       AS_n;
    logic       LDS_n;
    logic       RW;
    logic       CS_n;
    logic       IACK_n;
    logic [2:0] ADDR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;
    logic       DTACK_n;
    logic       IRQ_n;

    modport slave (
        input  AS_n, LDS_n, RW, CS_n, IACK_n, ADDR, DATA_IN,
        output DATA_OUT, DATA_OE, DTACK_n, IRQ_n
    );

    modport master (
        output AS_n, LDS_n, RW, CS_n, IACK_n, ADDR, DATA_IN,
        input  DATA_OUT, DATA_OE, DTACK_n, IRQ_n
    );
endinterface

// File: rtl/vectored_timer_responder.sv
// 68000 bus responder: 16-bit prescaled down-counting timer with its own DTACK and IACK vector.
// Latency AS_n fall -> DTACK_n low = 4 + DTACK_WAIT CLK; DTACK held until synchronised AS_n rises.
module vectored_timer_responder #(
    parameter int          PRESCALE     = 25,
    parameter int          DTACK_WAIT   = 1,
    parameter logic [7:0]  RESET_VECTOR = 8'h40
) (
    input logic                        CLK,
    input logic                        RST,
    vectored_timer_responder_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int WW = (DTACK_WAIT > 0) ? $clog2(DTACK_WAIT + 1) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [WW-1:0] W_INIT = WW'(DTACK_WAIT);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic          ack_entry;

    logic       as_m, as_s;
    logic       cs_q, iack_q, rw_q, lds_q;
    logic [2:0] addr_q;
    logic [7:0] din_q;

    logic          enable, irq_en, autoreload;
    logic [15:0]   reload, count;
    logic [7:0]    vector, shadow;
    logic          pending;
    logic [PW-1:0] presc;

    logic       tick, expire;
    logic       is_iack, reg_wr, reg_rd;
    logic [7:0] rd_val;

    // Bus qualifiers are captured on the same edge the synchronised strobe falls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            as_m   <= 1'b1;
            as_s   <= 1'b1;
            cs_q   <= 1'b1;
            iack_q <= 1'b1;
            rw_q   <= 1'b1;
            lds_q  <= 1'b1;
            addr_q <= 3'd0;
            din_q  <= 8'd0;
        end else begin
            as_m <= bus.AS_n;
            as_s <= as_m;
            if (as_s && !as_m) begin
                cs_q   <= bus.CS_n;
                iack_q <= bus.IACK_n;
                rw_q   <= bus.RW;
                lds_q  <= bus.LDS_n;
                addr_q <= bus.ADDR;
                din_q  <= bus.DATA_IN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        ack_entry = 1'b0;
        case (state)
            IDLE: begin
                if (!as_s && (!cs_q || !iack_q)) begin
                    state_nxt = WAIT;
                    wcnt_nxt  = W_INIT;
                end
            end
            WAIT: begin
                if (wcnt == '0) begin
                    state_nxt = ACK;
                    ack_entry = 1'b1;
                end else begin
                    wcnt_nxt = wcnt - WW'(1);
                end
            end
            ACK: begin
                if (as_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // IACK outranks a simultaneous register select.
    assign is_iack = !iack_q;
    assign reg_wr  = ack_entry && !is_iack && !cs_q && !rw_q && !lds_q;
    assign reg_rd  = ack_entry && !is_iack && !cs_q &&  rw_q && !lds_q;

    always_comb begin
        rd_val = 8'h00;
        case (addr_q)
            3'd0: rd_val = {5'd0, autoreload, irq_en, enable};
            3'd1: rd_val = reload[15:8];
            3'd2: rd_val = reload[7:0];
            3'd3: rd_val = count[15:8];
            3'd4: rd_val = shadow;
            3'd5: rd_val = vector;
            3'd6: rd_val = {7'd0, pending};
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.DTACK_n  <= 1'b1;
            bus.DATA_OE  <= 1'b0;
            bus.DATA_OUT <= 8'h00;
            bus.IRQ_n    <= 1'b1;
        end else begin
            bus.IRQ_n <= ~(pending & irq_en);
            if (ack_entry) begin
                bus.DTACK_n  <= 1'b0;
                bus.DATA_OE  <= rw_q;
                bus.DATA_OUT <= is_iack ? vector : (lds_q ? 8'hFF : rd_val);
            end else if (state == ACK && state_nxt == IDLE) begin
                bus.DTACK_n <= 1'b1;
                bus.DATA_OE <= 1'b0;
            end
        end
    end

    assign tick   = enable && (presc == P_LAST);
    assign expire = tick && (count == 16'd0);

    // Register writes are applied after the timer update so a write wins a same-cycle tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            enable     <= 1'b0;
            irq_en     <= 1'b0;
            autoreload <= 1'b0;
            reload     <= 16'hFFFF;
            count      <= 16'hFFFF;
            vector     <= RESET_VECTOR;
            shadow     <= 8'h00;
            pending    <= 1'b0;
            presc      <= '0;
        end else begin
            if (enable) presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                if (count == 16'd0) begin
                    if (autoreload) count  <= reload;
                    else            enable <= 1'b0;
                end else begin
                    count <= count - 16'd1;
                end
            end
            if (reg_wr) begin
                case (addr_q)
                    3'd0: {autoreload, irq_en, enable} <= din_q[2:0];
                    3'd1: reload[15:8] <= din_q;
                    3'd2: begin
                        reload[7:0] <= din_q;
                        count       <= {reload[15:8], din_q};
                        presc       <= '0;
                    end
                    3'd5: vector <= din_q;
                    default: ;
                endcase
            end
            if (reg_rd && addr_q == 3'd3) shadow <= count[7:0];
            pending <= expire |
                       (pending & ~((reg_wr && addr_q == 3'd6 && din_q[0]) ||
                                    (ack_entry && is_iack)));
        end
    end
endmodule

// File: tb/tb_vectored_timer_responder.sv
// Directed-plus-random bench for vectored_timer_responder; timer behaviour predicted arithmetically.
module tb_vectored_timer_responder;
    localparam int PRESCALE   = 4;
    localparam int DTACK_WAIT = 1;
    localparam int LAT        = 4 + DTACK_WAIT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vectored_timer_responder_if bif();

    vectored_timer_responder #(
        .PRESCALE(PRESCALE), .DTACK_WAIT(DTACK_WAIT), .RESET_VECTOR(8'h40)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bif)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_dtack(input logic lvl, input string tag, output int c);
        int n;
        n = 0;
        while (bif.DTACK_n !== lvl && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bif.DTACK_n !== lvl) begin
            checks++;
            failures++;
            $error("FAIL %s observed=timeout expected=DTACK_n=%0b", tag, lvl);
        end
        c = cyc;
    endtask

    task automatic wait_until(input int t, input string tag);
        if (cyc > t) begin
            checks++;
            failures++;
            $error("FAIL %s observed=cycle %0d expected=at most %0d", tag, cyc, t);
        end
        while (cyc < t) @(negedge clk);
    endtask

    task automatic xfer(input logic rw, input logic [2:0] a, input logic [7:0] d,
                        input logic iack, input logic cs, input logic lds,
                        output logic [7:0] rdat, output logic oe,
                        output int ent, output int lat, output int rlat);
        int c0, c1, c2;
        @(negedge clk);
        bif.RW = rw; bif.ADDR = a; bif.DATA_IN = d;
        bif.IACK_n = iack; bif.CS_n = cs; bif.LDS_n = lds; bif.AS_n = 1'b0;
        c0 = cyc;
        wait_dtack(1'b0, "dtack_assert", ent);
        lat  = ent - c0;
        rdat = bif.DATA_OUT;
        oe   = bif.DATA_OE;
        @(negedge clk);
        bif.AS_n = 1'b1; bif.CS_n = 1'b1; bif.IACK_n = 1'b1; bif.LDS_n = 1'b1; bif.RW = 1'b1;
        c1 = cyc;
        wait_dtack(1'b1, "dtack_release", c2);
        rlat = c2 - c1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d, output int ent);
        logic [7:0] r; logic oe; int lat, rl;
        xfer(1'b0, a, d, 1'b1, 1'b0, 1'b0, r, oe, ent, lat, rl);
        check("wr_latency", lat, LAT);
        check("wr_oe", oe, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] dat, output int ent);
        logic oe; int lat, rl;
        xfer(1'b1, a, 8'h00, 1'b1, 1'b0, 1'b0, dat, oe, ent, lat, rl);
        check("rd_latency", lat, LAT);
        check("rd_oe", oe, 1'b1);
    endtask

    // Timer model: count after edge t, loaded with v at edge t0, one tick per PRESCALE edges.
    function automatic logic [15:0] count_after(input int t, input int t0, input logic [15:0] v);
        return 16'(int'(v) - (t - t0) / PRESCALE);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=no finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  vec, r, hi, lo, rh, rl;
        logic [15:0] v;
        logic        oe;
        int          e, e2, lat, rlat, x;
        logic [7:0]  reset_tbl [8];

        reset_tbl = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h00, 8'h00};
        bif.AS_n = 1'b1; bif.LDS_n = 1'b1; bif.RW = 1'b1; bif.CS_n = 1'b1;
        bif.IACK_n = 1'b1; bif.ADDR = 3'd0; bif.DATA_IN = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dtack", bif.DTACK_n, 1'b1);
        check("rst_irq", bif.IRQ_n, 1'b1);
        check("rst_oe", bif.DATA_OE, 1'b0);
        check("rst_dout", bif.DATA_OUT, 8'h00);

        // Autoreload every 16 CLK with IRQ, vector delivered on IACK.
        vec = 8'($urandom_range(1, 255));
        wr(3'd5, vec, e);
        wr(3'd0, 8'h07, e);
        wr(3'd1, 8'h00, e);
        wr(3'd2, 8'h03, e);
        wait_until(e + 16, "t1_sched");
        check("t1_irq_before", bif.IRQ_n, 1'b1);
        wait_until(e + 17, "t1_sched");
        check("t1_irq_set", bif.IRQ_n, 1'b0);
        xfer(1'b1, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, r, oe, e2, lat, rlat);
        check("iack_vector", r, vec);
        check("iack_oe", oe, 1'b1);
        check("iack_latency", lat, LAT);
        check("iack_release", rlat <= 3, 1'b1);
        check("iack_irq_clear", bif.IRQ_n, 1'b1);
        wait_until(e + 32, "t1_sched");
        check("t1_irq_period_before", bif.IRQ_n, 1'b1);
        wait_until(e + 33, "t1_sched");
        check("t1_irq_period", bif.IRQ_n, 1'b0);

        // One-shot: a single expiry then enable drops and COUNT holds 0.
        wr(3'd0, 8'h00, e);
        wr(3'd1, 8'h00, e);
        wr(3'd2, 8'h02, e);
        wr(3'd6, 8'h01, e);
        wr(3'd0, 8'h03, e);
        wait_until(e + 30, "t3_sched");
        rd(3'd0, r, e2); check("oneshot_ctrl", r, 8'h02);
        rd(3'd6, r, e2); check("oneshot_pending", r, 8'h01);
        rd(3'd3, r, e2); check("oneshot_count_h", r, 8'h00);
        rd(3'd4, r, e2); check("oneshot_count_l", r, 8'h00);
        check("oneshot_irq", bif.IRQ_n, 1'b0);
        wr(3'd6, 8'h01, e);
        wait_until(cyc + 40, "t3_sched");
        rd(3'd6, r, e2); check("oneshot_single", r, 8'h00);
        rd(3'd3, r, e2); check("oneshot_hold", r, 8'h00);

        // Coherent 16-bit COUNT read through the shadow.
        wr(3'd0, 8'h05, e);
        rh = 8'($urandom_range(16, 240));
        rl = 8'($urandom);
        wr(3'd1, rh, e);
        wr(3'd2, rl, e);
        v = {rh, rl};
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            rd(3'd3, hi, e2);
            rd(3'd4, lo, x);
            check("count_snapshot", {hi, lo}, count_after(e2 - 1, e, v));
        end

        // STATUS clear racing an expiry, then an idle clear.
        wr(3'd1, 8'h00, e);
        wr(3'd0, 8'h07, e);
        wr(3'd2, 8'h07, e);
        wait_until(e + 65, "t5_sched");
        wr(3'd6, 8'h01, e2);
        x = e + 96;
        wait_until(x - 6, "t5_sched");
        check("t5_cleared_irq", bif.IRQ_n, 1'b1);
        wr(3'd6, 8'h01, e2);
        check("t5_collide_edge", e2, x);
        rd(3'd6, r, e2); check("t5_set_wins", r, 8'h01);
        check("t5_irq_held", bif.IRQ_n, 1'b0);
        wr(3'd6, 8'h01, e2);
        check("t5_idle_clear_irq", bif.IRQ_n, 1'b1);
        rd(3'd6, r, e2); check("t5_idle_clear", r, 8'h00);

        // Random register write/readback against a model of VECTOR and RELOAD_H.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            logic [2:0] a;
            d = 8'($urandom);
            a = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
            wr(a, d, e);
            if (a == 3'd5) vec = d;
            rd(a, r, e2);
            check("rand_readback", r, d);
        end
        rd(3'd5, r, e2); check("vector_model", r, vec);

        // LDS_n high: acknowledged but no write, reads return FF.
        xfer(1'b0, 3'd5, ~vec, 1'b1, 1'b0, 1'b1, r, oe, e, lat, rlat);
        check("lds_wr_latency", lat, LAT);
        rd(3'd5, r, e2); check("lds_wr_ignored", r, vec);
        xfer(1'b1, 3'd5, 8'h00, 1'b1, 1'b0, 1'b1, r, oe, e, lat, rlat);
        check("lds_rd_ff", r, 8'hFF);
        check("lds_rd_latency", lat, LAT);

        // Reset while the responder is holding DTACK.
        @(negedge clk);
        bif.RW = 1'b1; bif.ADDR = 3'd0; bif.CS_n = 1'b0; bif.LDS_n = 1'b0; bif.AS_n = 1'b0;
        wait_dtack(1'b0, "rst_ack_assert", e);
        check("rst_ack_oe_before", bif.DATA_OE, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        bif.AS_n = 1'b1; bif.CS_n = 1'b1; bif.LDS_n = 1'b1;
        @(negedge clk);
        check("rst_ack_dtack", bif.DTACK_n, 1'b1);
        check("rst_ack_oe", bif.DATA_OE, 1'b0);
        check("rst_ack_irq", bif.IRQ_n, 1'b1);
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), r, e2);
            check($sformatf("rst_reg%0d", a), r, reset_tbl[a]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
